mc_ctrl16: RTL and testbench

- Multicycle control sequencer for the 16-bit RISC-V datapath.
- Drives the clock-enable inputs of the datapath registers (PC, IR, A/B, ALUOut, MDR), the register-file write, and the ALU/mux selects.
- Runs a per-instruction state machine with a req/ack handshake to instruction/data memory.
- Sits between the instruction register output and the datapath enable network.

---
 rtl/mc_ctrl16.sv | 156 +++++++++++++++
 tb/tb_mc_ctrl16.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl16.sv
// mc_ctrl16: multicycle control sequencer for the 16-bit RISC-V datapath.
// Moore decode of state; enables qualified by mem_ack are combinational.
module mc_ctrl16 #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ack,
    output logic           mem_req,
    output logic           mem_we,
    output logic           pc_en,
    output logic           ir_en,
    output logic           ab_en,
    output logic           alu_en,
    output logic           mdr_en,
    output logic           rf_we,
    output logic [1:0]     alu_sel,
    output logic           pc_sel,
    output logic           busy,
    output logic           err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [OPW-1:0] OP_ALUR  = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ALUI  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_STORE = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_BR    = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [OPW-1:0] r_op;
    logic [3:0]     r_wait;
    logic           r_err;
    logic           w_in_mem;
    logic           w_timeout;

    assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEM);
    // The wait that would bring the counter up to MAX_WAIT is the one that times out.
    assign w_timeout = (r_wait == 4'(MAX_WAIT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (run) w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ack)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ALUR, OP_ALUI, OP_LOAD,
                    OP_STORE, OP_BR, OP_JAL: w_next = S_EXEC;
                    OP_HALT:                 w_next = S_HALT;
                    default:                 w_next = S_ERR;
                endcase
            end
            S_EXEC: begin
                if ((r_op == OP_LOAD) || (r_op == OP_STORE))     w_next = S_MEM;
                else if ((r_op == OP_ALUR) || (r_op == OP_ALUI)) w_next = S_WB;
                else                                             w_next = S_FETCH;
            end
            S_MEM: begin
                if (mem_ack)        w_next = (r_op == OP_LOAD) ? S_WB : S_FETCH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_WB:    w_next = S_FETCH;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
            // Counter clears in every other state, so entry to FETCH/MEM starts at zero.
            r_wait  <= (w_in_mem && !mem_ack) ? r_wait + 4'd1 : '0;
            if (w_next == S_ERR) r_err <= 1'b1;
        end
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        ab_en   = 1'b0;
        alu_en  = 1'b0;
        mdr_en  = 1'b0;
        rf_we   = 1'b0;
        alu_sel = 2'b00;
        pc_sel  = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_en   = mem_ack;
                    pc_en   = mem_ack;
                end
                S_DECODE: ab_en = 1'b1;
                S_EXEC: begin
                    case (r_op)
                        OP_ALUR, OP_ALUI: begin
                            alu_en  = 1'b1;
                            alu_sel = 2'b01;
                        end
                        OP_BR: begin
                            alu_sel = 2'b10;
                            pc_en   = zero;
                            pc_sel  = zero;
                        end
                        OP_JAL: begin
                            alu_en  = 1'b1;
                            alu_sel = 2'b11;
                            pc_en   = 1'b1;
                            pc_sel  = 1'b1;
                            rf_we   = 1'b1;
                        end
                        default: alu_en = 1'b1;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (r_op == OP_STORE);
                    mdr_en  = mem_ack && (r_op == OP_LOAD);
                end
                S_WB:    rf_we = 1'b1;
                default: ;
            endcase
            busy = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
            err  = r_err;
        end
    end

endmodule

// File: tb/tb_mc_ctrl16.sv
// tb_mc_ctrl16: instruction-level trace model of the sequencer, driven with
// randomized programs, memory latencies and don't-care inputs.
module tb_mc_ctrl16;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, pc_en, ir_en, ab_en, alu_en, mdr_en, rf_we;
    logic [1:0] alu_sel;
    logic       pc_sel, busy, err;
    logic [12:0] w_obs;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] REQ  = 13'h1000;
    localparam logic [12:0] WE   = 13'h0800;
    localparam logic [12:0] PCE  = 13'h0400;
    localparam logic [12:0] IRE  = 13'h0200;
    localparam logic [12:0] ABE  = 13'h0100;
    localparam logic [12:0] ALUE = 13'h0080;
    localparam logic [12:0] MDRE = 13'h0040;
    localparam logic [12:0] RFW  = 13'h0020;
    localparam logic [12:0] S01  = 13'h0008;
    localparam logic [12:0] S10  = 13'h0010;
    localparam logic [12:0] S11  = 13'h0018;
    localparam logic [12:0] PSEL = 13'h0004;
    localparam logic [12:0] BSY  = 13'h0002;
    localparam logic [12:0] ERRB = 13'h0001;

    mc_ctrl16 #(.OPW(4), .MAX_WAIT(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .opcode  (opcode),
        .zero    (zero),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .pc_en   (pc_en),
        .ir_en   (ir_en),
        .ab_en   (ab_en),
        .alu_en  (alu_en),
        .mdr_en  (mdr_en),
        .rf_we   (rf_we),
        .alu_sel (alu_sel),
        .pc_sel  (pc_sel),
        .busy    (busy),
        .err     (err)
    );

    assign w_obs = {mem_req, mem_we, pc_en, ir_en, ab_en, alu_en, mdr_en, rf_we,
                    alu_sel, pc_sel, busy, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, check outputs at the falling edge.
    task automatic step(input string tag, input logic r, input logic [3:0] op, input logic z,
                        input logic ack, input logic rn, input logic [12:0] exp);
        @(posedge clk);
        #1;
        run     = r;
        opcode  = op;
        zero    = z;
        mem_ack = ack;
        rst_n   = rn;
        @(negedge clk);
        chk(tag, w_obs, exp);
    endtask

    // Expected trace of one instruction starting in FETCH, from the instruction's class.
    task automatic run_instr(input logic [3:0] op, input int unsigned fw,
                             input int unsigned mw, input logic z);
        for (int unsigned i = 0; i < fw; i++)
            step("fetch_wait", rb(), ro(), rb(), 1'b0, 1'b1, REQ | BSY);
        step("fetch_ack", rb(), ro(), rb(), 1'b1, 1'b1, REQ | IRE | PCE | BSY);
        step("decode", rb(), op, rb(), rb(), 1'b1, ABE | BSY);
        case (op)
            4'h0, 4'h1: begin
                step("exec_alu", rb(), ro(), rb(), rb(), 1'b1, ALUE | S01 | BSY);
                step("wb_alu", rb(), ro(), rb(), rb(), 1'b1, RFW | BSY);
            end
            4'h2: begin
                step("exec_ld", rb(), ro(), rb(), rb(), 1'b1, ALUE | BSY);
                for (int unsigned i = 0; i < mw; i++)
                    step("mem_ld_wait", rb(), ro(), rb(), 1'b0, 1'b1, REQ | BSY);
                step("mem_ld_ack", rb(), ro(), rb(), 1'b1, 1'b1, REQ | MDRE | BSY);
                step("wb_ld", rb(), ro(), rb(), rb(), 1'b1, RFW | BSY);
            end
            4'h3: begin
                step("exec_st", rb(), ro(), rb(), rb(), 1'b1, ALUE | BSY);
                for (int unsigned i = 0; i < mw; i++)
                    step("mem_st_wait", rb(), ro(), rb(), 1'b0, 1'b1, REQ | WE | BSY);
                step("mem_st_ack", rb(), ro(), rb(), 1'b1, 1'b1, REQ | WE | BSY);
            end
            4'h4: step("exec_br", rb(), ro(), z, rb(), 1'b1,
                       S10 | BSY | (z ? (PCE | PSEL) : NONE));
            4'h5: step("exec_jal", rb(), ro(), rb(), rb(), 1'b1,
                       ALUE | S11 | PCE | PSEL | RFW | BSY);
            default: ;
        endcase
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ack = 1'b0;

        step("reset0", 1'b1, ro(), rb(), 1'b1, 1'b0, NONE);
        step("reset1", 1'b1, ro(), rb(), 1'b1, 1'b0, NONE);
        step("idle", 1'b0, ro(), rb(), rb(), 1'b1, NONE);
        step("idle_hold", 1'b0, ro(), rb(), rb(), 1'b1, NONE);
        step("idle_run", 1'b1, ro(), rb(), rb(), 1'b1, NONE);

        run_instr(4'h0, 0, 0, 1'b0);
        run_instr(4'h2, 0, 3, 1'b0);
        run_instr(4'h3, 1, 2, 1'b0);
        run_instr(4'h4, 0, 0, 1'b1);
        run_instr(4'h4, 0, 0, 1'b0);
        run_instr(4'h5, 2, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(0, 5)), $urandom_range(0, 4), $urandom_range(0, 4), rb());
        run_instr(4'h1, 14, 0, 1'b0);
        run_instr(4'h2, 0, 14, 1'b0);

        // Illegal opcode: sticky error, run ignored, reset clears it.
        step("fetch_ack_ill", 1'b0, ro(), rb(), 1'b1, 1'b1, REQ | IRE | PCE | BSY);
        step("decode_ill", 1'b0, 4'hA, rb(), rb(), 1'b1, ABE | BSY);
        for (int i = 0; i < 3; i++)
            step("err_sticky", 1'b1, ro(), rb(), rb(), 1'b1, ERRB);
        step("err_reset", 1'b1, ro(), rb(), rb(), 1'b0, NONE);
        step("err_cleared", 1'b1, ro(), rb(), rb(), 1'b1, NONE);

        // Fetch timeout.
        for (int i = 0; i < 15; i++)
            step("fetch_to_wait", rb(), ro(), rb(), 1'b0, 1'b1, REQ | BSY);
        step("timeout_err", 1'b1, ro(), rb(), 1'b1, 1'b1, ERRB);
        step("to_err_hold", 1'b1, ro(), rb(), 1'b1, 1'b1, ERRB);
        step("to_reset", 1'b0, ro(), rb(), rb(), 1'b0, NONE);
        step("to_idle", 1'b1, ro(), rb(), rb(), 1'b1, NONE);

        // Reset in MEM coinciding with an ack.
        step("fetch_ack_rm", 1'b0, ro(), rb(), 1'b1, 1'b1, REQ | IRE | PCE | BSY);
        step("decode_rm", 1'b0, 4'h2, rb(), rb(), 1'b1, ABE | BSY);
        step("exec_rm", 1'b0, ro(), rb(), rb(), 1'b1, ALUE | BSY);
        step("mem_rm_wait", 1'b0, ro(), rb(), 1'b0, 1'b1, REQ | BSY);
        step("mem_rm_reset", 1'b0, ro(), rb(), 1'b1, 1'b0, NONE);
        step("rm_idle", 1'b0, ro(), rb(), 1'b1, 1'b1, NONE);
        step("rm_idle_run", 1'b1, ro(), rb(), rb(), 1'b1, NONE);

        // HALT.
        step("fetch_ack_h", 1'b0, ro(), rb(), 1'b1, 1'b1, REQ | IRE | PCE | BSY);
        step("decode_h", 1'b0, 4'hF, rb(), rb(), 1'b1, ABE | BSY);
        for (int i = 0; i < 3; i++)
            step("halt", 1'b1, ro(), rb(), 1'b1, 1'b1, NONE);
        step("halt_reset", 1'b0, ro(), rb(), rb(), 1'b0, NONE);
        step("halt_idle", 1'b0, ro(), rb(), rb(), 1'b1, NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
